// File: rtl/ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared types and constants for the control-loop sequencer.
//   seq_state_e : sequencer FSM encoding
//   GAIN_*      : slice indices into the packed {vel_p,vel_i,cur_p,cur_i} gain set
//   mag19       : sign-magnitude helper for the overcurrent check
// -----------------------------------------------------------------------------
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_COMMIT,
    ST_STEP,
    ST_WAIT
  } seq_state_e;

  localparam int GAIN_W     = 18;
  localparam int GAIN_VEL_P = 3;
  localparam int GAIN_VEL_I = 2;
  localparam int GAIN_CUR_P = 1;
  localparam int GAIN_CUR_I = 0;
  localparam int GAINS_W    = 4 * GAIN_W;

  // |v| one bit wider than v so the most negative sample (-2^17) maps to
  // +2^17 instead of wrapping back to itself.
  function automatic logic [GAIN_W:0] mag19(input logic [GAIN_W-1:0] v);
    logic [GAIN_W:0] ext;
    ext = {v[GAIN_W-1], v};
    return v[GAIN_W-1] ? (~ext + 19'd1) : ext;
  endfunction

endpackage

// File: rtl/controller_loop_sequencer_if.sv
// -----------------------------------------------------------------------------
// controller_loop_sequencer_if
// Bundles the AXI-register / ADC side signals of the sequencer.
//   master : AXI register bank + ADC (drives requests and samples)
//   slave  : controller_loop_sequencer
// -----------------------------------------------------------------------------
interface controller_loop_sequencer_if;
  import ctrl_seq_pkg::*;

  logic               enable;
  logic               adc_done;
  logic [GAIN_W-1:0]  adc_current_0;
  logic [GAIN_W-1:0]  adc_current_1;
  logic [GAINS_W-1:0] cfg_gains_in;
  logic               cfg_update_req;
  logic               err_clear;

  logic               adc_start;
  logic [GAIN_W-1:0]  phase_current_a;
  logic [GAIN_W-1:0]  phase_current_b;
  logic [GAINS_W-1:0] gains_out;
  logic               cfg_update_ack;
  logic               clk_enable_2000;
  logic               inverter_enable;
  logic               overcurrent_error;
  logic               adc_timeout_error;

  modport master (
    output enable, adc_done, adc_current_0, adc_current_1,
           cfg_gains_in, cfg_update_req, err_clear,
    input  adc_start, phase_current_a, phase_current_b, gains_out,
           cfg_update_ack, clk_enable_2000, inverter_enable,
           overcurrent_error, adc_timeout_error
  );

  modport slave (
    input  enable, adc_done, adc_current_0, adc_current_1,
           cfg_gains_in, cfg_update_req, err_clear,
    output adc_start, phase_current_a, phase_current_b, gains_out,
           cfg_update_ack, clk_enable_2000, inverter_enable,
           overcurrent_error, adc_timeout_error
  );

endinterface

// File: rtl/controller_period_timer.sv
// -----------------------------------------------------------------------------
// controller_period_timer
// Control-period counter: counts 0..CLK_DIV-1 while run is high and wraps,
// held at 0 while run is low so every run starts a fresh period.
//   clk_in      : clock
//   reset       : synchronous, active-high
//   run         : count enable (sequencer active)
//   period_tick : high on the last cycle of the period
// -----------------------------------------------------------------------------
module controller_period_timer #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic run,
  output logic period_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (reset || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign period_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/controller_loop_sequencer.sv
// -----------------------------------------------------------------------------
// controller_loop_sequencer
// Sequences one control period: ADC sample handshake, period-boundary gain
// commit, sticky fault latches and the per-period step strobe.
//   clk_in : clock
//   reset  : synchronous, active-high
//   bus    : AXI/ADC side signals (controller_loop_sequencer_if.slave)
//
// state  | meaning
// IDLE   | loop stopped, counter held at 0
// SAMPLE | adc_start high, waiting for adc_done or timeout
// COMMIT | apply pending gain update, overcurrent check on latched sample
// STEP   | clk_enable_2000 strobe cycle
// WAIT   | wait for end of control period
// -----------------------------------------------------------------------------
module controller_loop_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned       CLK_DIV     = 50000,
  parameter int unsigned       ADC_TIMEOUT = 256,
  parameter logic [GAIN_W-1:0] OC_LIMIT    = 18'd100000
) (
  input  logic                        clk_in,
  input  logic                        reset,
  controller_loop_sequencer_if.slave  bus
);

  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(ADC_TIMEOUT - 1);
  localparam logic [GAIN_W:0] OC_LIM19 = {1'b0, OC_LIMIT};

  seq_state_e         state_q;
  logic [TW-1:0]      tmo_q;
  logic               adc_start_q;
  logic [GAIN_W-1:0]  pha_q;
  logic [GAIN_W-1:0]  phb_q;
  logic [GAINS_W-1:0] gains_q;
  logic               ack_q;
  logic               strobe_q;
  logic               inv_q;
  logic               oc_err_q;
  logic               to_err_q;
  logic               pending_q;

  logic run;
  logic period_tick;

  // Dropping enable zeroes the counter on the same edge the FSM returns to
  // IDLE, so a re-enable always begins at count 0.
  assign run = bus.enable && (state_q != ST_IDLE);

  controller_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_in      (clk_in),
    .reset       (reset),
    .run         (run),
    .period_tick (period_tick)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      adc_start_q <= 1'b0;
      pha_q       <= '0;
      phb_q       <= '0;
      gains_q     <= '0;
      ack_q       <= 1'b0;
      strobe_q    <= 1'b0;
      inv_q       <= 1'b0;
      oc_err_q    <= 1'b0;
      to_err_q    <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      inv_q    <= bus.enable & ~oc_err_q & ~to_err_q & (state_q != ST_IDLE);

      // Clears and request capture come first; a fault set or a commit later
      // in this block overrides them on the same edge.
      if (bus.err_clear) begin
        oc_err_q <= 1'b0;
        to_err_q <= 1'b0;
      end
      if (bus.cfg_update_req) pending_q <= 1'b1;

      if (!bus.enable) begin
        state_q     <= ST_IDLE;
        adc_start_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q     <= ST_SAMPLE;
            adc_start_q <= 1'b1;
            tmo_q       <= TMO_LOAD;
          end
          ST_SAMPLE: begin
            if (bus.adc_done) begin
              pha_q       <= bus.adc_current_0;
              phb_q       <= bus.adc_current_1;
              adc_start_q <= 1'b0;
              state_q     <= ST_COMMIT;
            end else if (tmo_q == '0) begin
              to_err_q    <= 1'b1;
              adc_start_q <= 1'b0;
              state_q     <= ST_COMMIT;
            end else begin
              tmo_q <= tmo_q - TW'(1);
            end
          end
          ST_COMMIT: begin
            if (pending_q || bus.cfg_update_req) begin
              gains_q[GAIN_VEL_P*GAIN_W +: GAIN_W] <= bus.cfg_gains_in[GAIN_VEL_P*GAIN_W +: GAIN_W];
              gains_q[GAIN_VEL_I*GAIN_W +: GAIN_W] <= bus.cfg_gains_in[GAIN_VEL_I*GAIN_W +: GAIN_W];
              gains_q[GAIN_CUR_P*GAIN_W +: GAIN_W] <= bus.cfg_gains_in[GAIN_CUR_P*GAIN_W +: GAIN_W];
              gains_q[GAIN_CUR_I*GAIN_W +: GAIN_W] <= bus.cfg_gains_in[GAIN_CUR_I*GAIN_W +: GAIN_W];
              ack_q     <= 1'b1;
              pending_q <= 1'b0;
            end
            if ((mag19(pha_q) > OC_LIM19) || (mag19(phb_q) > OC_LIM19)) begin
              oc_err_q <= 1'b1;
            end
            strobe_q <= 1'b1;
            state_q  <= ST_STEP;
          end
          ST_STEP: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (period_tick) begin
              state_q     <= ST_SAMPLE;
              adc_start_q <= 1'b1;
              tmo_q       <= TMO_LOAD;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            adc_start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.adc_start         = adc_start_q;
  assign bus.phase_current_a   = pha_q;
  assign bus.phase_current_b   = phb_q;
  assign bus.gains_out         = gains_q;
  assign bus.cfg_update_ack    = ack_q;
  assign bus.clk_enable_2000   = strobe_q;
  assign bus.inverter_enable   = inv_q;
  assign bus.overcurrent_error = oc_err_q;
  assign bus.adc_timeout_error = to_err_q;

endmodule
